// File: rtl/vc_domain_pipe_buffer.sv
// Two-entry valid/ready buffer (main + skid) with per-entry domain tag, dead-slot scrubbing and domain flush.
// States: EMPTY = no entry | ONE = main valid | FULL = main and skid valid
module vc_domain_pipe_buffer #(
    parameter int p_nbits = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               in_val_i,
    output logic               in_rdy_o,
    input  logic               in_dom_i,
    input  logic [p_nbits-1:0] in_msg_i,
    output logic               out_val_o,
    input  logic               out_rdy_i,
    output logic               out_dom_o,
    output logic [p_nbits-1:0] out_msg_o,
    input  logic               flush_i,
    input  logic               flush_dom_i,
    output logic [1:0]         count_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [p_nbits-1:0] main_msg_q, main_msg_d;
    logic               main_dom_q, main_dom_d;
    logic [p_nbits-1:0] skid_msg_q, skid_msg_d;
    logic               skid_dom_q, skid_dom_d;

    logic               in_fire, out_fire;
    logic               a_v, b_v;
    logic               a_dom, b_dom;
    logic [p_nbits-1:0] a_msg, b_msg;

    assign in_rdy_o  = (state_q != ST_FULL);
    assign out_val_o = (state_q != ST_EMPTY);
    assign out_msg_o = main_msg_q;
    assign out_dom_o = main_dom_q;
    assign count_o   = (state_q == ST_FULL) ? 2'd2 : ((state_q == ST_ONE) ? 2'd1 : 2'd0);

    assign in_fire  = in_val_i & in_rdy_o;
    assign out_fire = out_val_o & out_rdy_i;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= ST_EMPTY;
            main_msg_q <= '0;
            main_dom_q <= 1'b0;
            skid_msg_q <= '0;
            skid_dom_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_msg_q <= main_msg_d;
            main_dom_q <= main_dom_d;
            skid_msg_q <= skid_msg_d;
            skid_dom_q <= skid_dom_d;
        end
    end

    // a = older surviving candidate, b = newer; normal transfer first, then flush filter, then compaction.
    always_comb begin
        a_v   = 1'b0;
        a_dom = 1'b0;
        a_msg = '0;
        b_v   = 1'b0;
        b_dom = 1'b0;
        b_msg = '0;
        unique case (state_q)
            ST_EMPTY: begin
                a_v   = in_fire;
                a_dom = in_dom_i;
                a_msg = in_msg_i;
            end
            ST_ONE: begin
                if (out_fire) begin
                    a_v   = in_fire;
                    a_dom = in_dom_i;
                    a_msg = in_msg_i;
                end else begin
                    a_v   = 1'b1;
                    a_dom = main_dom_q;
                    a_msg = main_msg_q;
                    b_v   = in_fire;
                    b_dom = in_dom_i;
                    b_msg = in_msg_i;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    a_v   = 1'b1;
                    a_dom = skid_dom_q;
                    a_msg = skid_msg_q;
                end else begin
                    a_v   = 1'b1;
                    a_dom = main_dom_q;
                    a_msg = main_msg_q;
                    b_v   = 1'b1;
                    b_dom = skid_dom_q;
                    b_msg = skid_msg_q;
                end
            end
            default: ;
        endcase

        if (flush_i && (a_dom == flush_dom_i)) a_v = 1'b0;
        if (flush_i && (b_dom == flush_dom_i)) b_v = 1'b0;

        main_msg_d = '0;
        main_dom_d = 1'b0;
        skid_msg_d = '0;
        skid_dom_d = 1'b0;
        state_d    = ST_EMPTY;
        if (a_v) begin
            main_msg_d = a_msg;
            main_dom_d = a_dom;
            state_d    = ST_ONE;
            if (b_v) begin
                skid_msg_d = b_msg;
                skid_dom_d = b_dom;
                state_d    = ST_FULL;
            end
        end else if (b_v) begin
            main_msg_d = b_msg;
            main_dom_d = b_dom;
            state_d    = ST_ONE;
        end
    end

    a_inputs_known: assert property (@(posedge clk_i) disable iff (!reset_i)
        !$isunknown({in_val_i, out_rdy_i, flush_i}));
    a_one_entry_live: assert property (@(posedge clk_i) disable iff (!reset_i)
        (count_o == 2'd1) |-> (in_rdy_o || out_val_o));

endmodule

// File: tb/tb_vc_domain_pipe_buffer.sv
// Bench for vc_domain_pipe_buffer: directed scenarios plus random traffic against a queue model.
module tb_vc_domain_pipe_buffer;

    typedef struct packed {
        logic        dom;
        logic [31:0] msg;
    } ent_t;

    logic        clk_i       = 1'b0;
    logic        reset_i     = 1'b0;
    logic        in_val_i    = 1'b0;
    logic        in_rdy_o;
    logic        in_dom_i    = 1'b0;
    logic [31:0] in_msg_i    = '0;
    logic        out_val_o;
    logic        out_rdy_i   = 1'b0;
    logic        out_dom_o;
    logic [31:0] out_msg_o;
    logic        flush_i     = 1'b0;
    logic        flush_dom_i = 1'b0;
    logic [1:0]  count_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t mq[$];

    vc_domain_pipe_buffer #(.p_nbits(32)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .in_val_i   (in_val_i),
        .in_rdy_o   (in_rdy_o),
        .in_dom_i   (in_dom_i),
        .in_msg_i   (in_msg_i),
        .out_val_o  (out_val_o),
        .out_rdy_i  (out_rdy_i),
        .out_dom_o  (out_dom_o),
        .out_msg_o  (out_msg_o),
        .flush_i    (flush_i),
        .flush_dom_i(flush_dom_i),
        .count_o    (count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int          n;
        logic [31:0] emsg;
        logic        edom;
        n    = mq.size();
        emsg = (n > 0) ? mq[0].msg : 32'h0;
        edom = (n > 0) ? mq[0].dom : 1'b0;
        chk({tag, "_count"},   32'(count_o),   32'(n));
        chk({tag, "_out_val"}, 32'(out_val_o), 32'(n > 0));
        chk({tag, "_in_rdy"},  32'(in_rdy_o),  32'(n < 2));
        chk({tag, "_out_msg"}, out_msg_o,      emsg);
        chk({tag, "_out_dom"}, 32'(out_dom_o), 32'(edom));
    endtask

    // Called at a falling edge; drives inputs, advances the model, then checks at the next falling edge.
    task automatic cycle(input logic iv, input logic id, input logic [31:0] im,
                         input logic ordy, input logic fl, input logic fd);
        logic inf, outf;
        ent_t keep[$];
        in_val_i    = iv;
        in_dom_i    = id;
        in_msg_i    = im;
        out_rdy_i   = ordy;
        flush_i     = fl;
        flush_dom_i = fd;
        inf  = iv && (mq.size() < 2);
        outf = ordy && (mq.size() > 0);
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back('{dom: id, msg: im});
        if (fl) begin
            foreach (mq[i]) if (mq[i].dom != fd) keep.push_back(mq[i]);
            mq = keep;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        check_model("model");
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        chk("reset_out_val", 32'(out_val_o), 32'd0);
        chk("reset_in_rdy",  32'(in_rdy_o),  32'd1);
        chk("reset_count",   32'(count_o),   32'd0);
        chk("reset_out_msg", out_msg_o,      32'd0);

        cycle(1, 0, 32'hA5, 1, 0, 0);
        chk("t1_out_val", 32'(out_val_o), 32'd1);
        chk("t1_out_msg", out_msg_o,      32'hA5);
        chk("t1_count",   32'(count_o),   32'd1);

        for (int i = 1; i <= 4; i++) begin
            cycle(1, 0, 32'(i), 1, 0, 0);
            chk("t2_out_msg", out_msg_o,     32'(i));
            chk("t2_in_rdy",  32'(in_rdy_o), 32'd1);
        end
        cycle(0, 0, 0, 1, 0, 0);

        cycle(1, 0, 32'h11, 0, 0, 0);
        cycle(1, 0, 32'h22, 0, 0, 0);
        chk("t3_count_full", 32'(count_o),  32'd2);
        chk("t3_in_rdy",     32'(in_rdy_o), 32'd0);
        chk("t3_head0",      out_msg_o,     32'h11);
        cycle(0, 0, 0, 1, 0, 0);
        chk("t3_head1",      out_msg_o,     32'h22);
        cycle(0, 0, 0, 1, 0, 0);
        chk("t3_drained_val", 32'(out_val_o), 32'd0);
        chk("t3_drained_msg", out_msg_o,      32'd0);

        cycle(1, 1, 32'h11, 0, 0, 0);
        cycle(1, 0, 32'h22, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 1);
        chk("t4_out_msg", out_msg_o,      32'h22);
        chk("t4_out_dom", 32'(out_dom_o), 32'd0);
        chk("t4_count",   32'(count_o),   32'd1);
        cycle(0, 0, 0, 1, 0, 0);

        cycle(1, 1, 32'h33, 0, 0, 0);
        cycle(1, 1, 32'h44, 1, 1, 1);
        chk("t5_count",   32'(count_o),   32'd0);
        chk("t5_out_msg", out_msg_o,      32'd0);
        chk("t5_out_val", 32'(out_val_o), 32'd0);

        cycle(1, 0, 32'h55, 0, 0, 0);
        cycle(1, 1, 32'h66, 0, 0, 0);
        in_val_i = 1'b0;
        #2 reset_i = 1'b0;
        #1;
        chk("t6_out_val", 32'(out_val_o), 32'd0);
        chk("t6_in_rdy",  32'(in_rdy_o),  32'd1);
        chk("t6_out_msg", out_msg_o,      32'd0);
        chk("t6_count",   32'(count_o),   32'd0);
        mq.delete();
        @(negedge clk_i);
        reset_i = 1'b1;

        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 4) != 0, 1'($urandom), $urandom,
                  ($urandom % 3) != 0, ($urandom % 8) == 0, 1'($urandom));
        end
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        chk("final_empty", 32'(count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
